// File: rtl/keypad_lock_ctrl_if.sv
// Key-entry and status signals of the keypad lock controller.
// The master drives keys and mode; the slave reports lock state and pulses.
interface keypad_lock_ctrl_if #(
    parameter int DIGITS       = 8,
    parameter int MAX_ATTEMPTS = 3
);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int CW = $clog2(DIGITS + 1);

    logic          key_valid;
    logic [3:0]    key_code;
    logic          mode_set;
    logic          alarm_clr;
    logic          unlocked;
    logic          alarm;
    logic [AW-1:0] attempt_count;
    logic [CW-1:0] digit_count;
    logic          fail;
    logic          prog_ok;
    logic          prog_err;

    modport master (
        output key_valid, key_code, mode_set, alarm_clr,
        input  unlocked, alarm, attempt_count, digit_count, fail, prog_ok, prog_err
    );

    modport slave (
        input  key_valid, key_code, mode_set, alarm_clr,
        output unlocked, alarm, attempt_count, digit_count, fail, prog_ok, prog_err
    );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock: buffers BCD digits, compares against a programmable passcode,
// counts failed attempts into an alarm and relocks after a fixed unlock window.
module keypad_lock_ctrl #(
    parameter int                    DIGITS        = 8,
    parameter int                    MAX_ATTEMPTS  = 3,
    parameter int                    UNLOCK_CYCLES = 1000,
    parameter logic [4*DIGITS-1:0]   DEFAULT_CODE  = {(4*DIGITS){1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    keypad_lock_ctrl_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(UNLOCK_CYCLES);

    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_ALARM    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] entry_buf_q, entry_buf_d;
    logic [CW-1:0] entry_cnt_q, entry_cnt_d;
    logic [BW-1:0] prog_buf_q, prog_buf_d;
    logic [CW-1:0] prog_cnt_q, prog_cnt_d;
    logic [BW-1:0] code_q, code_d;
    logic [AW-1:0] attempt_q, attempt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          unlocked_q, alarm_q;
    logic          fail_q, fail_d;
    logic          prog_ok_q, prog_ok_d;
    logic          prog_err_q, prog_err_d;

    logic          is_digit_s, is_clear_s, is_enter_s;

    function automatic logic [BW-1:0] shift_in(input logic [BW-1:0] buf_v, input logic [3:0] digit);
        logic [BW+3:0] wide_v;
        wide_v = {buf_v, digit};
        return wide_v[BW-1:0];
    endfunction

    assign is_digit_s = (bus.key_code <= 4'd9);
    assign is_clear_s = (bus.key_code == KEY_CLEAR);
    assign is_enter_s = (bus.key_code == KEY_ENTER);

    // Next-state, buffer, attempt and timer logic.
    always_comb begin
        state_d     = state_q;
        entry_buf_d = entry_buf_q;
        entry_cnt_d = entry_cnt_q;
        prog_buf_d  = prog_buf_q;
        prog_cnt_d  = prog_cnt_q;
        code_d      = code_q;
        attempt_d   = attempt_q;
        timer_d     = timer_q;
        fail_d      = 1'b0;
        prog_ok_d   = 1'b0;
        prog_err_d  = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (bus.key_valid) begin
                    if (is_digit_s) begin
                        if (entry_cnt_q < CW'(DIGITS)) begin
                            entry_buf_d = shift_in(entry_buf_q, bus.key_code);
                            entry_cnt_d = entry_cnt_q + CW'(1);
                        end else begin
                            entry_cnt_d = entry_cnt_q;
                        end
                    end else if (is_clear_s) begin
                        entry_buf_d = {BW{1'b0}};
                        entry_cnt_d = {CW{1'b0}};
                    end else if (is_enter_s) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else begin
                    state_d = ST_ENTRY;
                end
            end

            ST_CHECK: begin
                entry_buf_d = {BW{1'b0}};
                entry_cnt_d = {CW{1'b0}};
                if ((entry_cnt_q == CW'(DIGITS)) && (entry_buf_q == code_q)) begin
                    state_d   = ST_UNLOCKED;
                    attempt_d = {AW{1'b0}};
                    timer_d   = TW'(UNLOCK_CYCLES - 1);
                end else begin
                    fail_d    = 1'b1;
                    attempt_d = attempt_q + AW'(1);
                    if ((attempt_q + AW'(1)) == AW'(MAX_ATTEMPTS)) begin
                        state_d = ST_ALARM;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end
            end

            ST_UNLOCKED: begin
                if (bus.mode_set) begin
                    // Timer holds while programming; only the program buffer moves.
                    if (bus.key_valid) begin
                        if (is_digit_s) begin
                            if (prog_cnt_q < CW'(DIGITS)) begin
                                prog_buf_d = shift_in(prog_buf_q, bus.key_code);
                                prog_cnt_d = prog_cnt_q + CW'(1);
                            end else begin
                                prog_cnt_d = prog_cnt_q;
                            end
                        end else if (is_clear_s) begin
                            prog_buf_d = {BW{1'b0}};
                            prog_cnt_d = {CW{1'b0}};
                        end else if (is_enter_s) begin
                            prog_buf_d = {BW{1'b0}};
                            prog_cnt_d = {CW{1'b0}};
                            if (prog_cnt_q == CW'(DIGITS)) begin
                                code_d    = prog_buf_q;
                                prog_ok_d = 1'b1;
                                state_d   = ST_ENTRY;
                            end else begin
                                prog_err_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_UNLOCKED;
                        end
                    end else begin
                        state_d = ST_UNLOCKED;
                    end
                end else if (timer_q == {TW{1'b0}}) begin
                    state_d    = ST_ENTRY;
                    prog_buf_d = {BW{1'b0}};
                    prog_cnt_d = {CW{1'b0}};
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_ALARM: begin
                if (bus.alarm_clr) begin
                    state_d     = ST_ENTRY;
                    attempt_d   = {AW{1'b0}};
                    entry_buf_d = {BW{1'b0}};
                    entry_cnt_d = {CW{1'b0}};
                    prog_buf_d  = {BW{1'b0}};
                    prog_cnt_d  = {CW{1'b0}};
                end else begin
                    state_d = ST_ALARM;
                end
            end

            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    // State and datapath registers; status outputs are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ENTRY;
            entry_buf_q <= {BW{1'b0}};
            entry_cnt_q <= {CW{1'b0}};
            prog_buf_q  <= {BW{1'b0}};
            prog_cnt_q  <= {CW{1'b0}};
            code_q      <= DEFAULT_CODE;
            attempt_q   <= {AW{1'b0}};
            timer_q     <= {TW{1'b0}};
            unlocked_q  <= 1'b0;
            alarm_q     <= 1'b0;
            fail_q      <= 1'b0;
            prog_ok_q   <= 1'b0;
            prog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_buf_q <= entry_buf_d;
            entry_cnt_q <= entry_cnt_d;
            prog_buf_q  <= prog_buf_d;
            prog_cnt_q  <= prog_cnt_d;
            code_q      <= code_d;
            attempt_q   <= attempt_d;
            timer_q     <= timer_d;
            unlocked_q  <= (state_d == ST_UNLOCKED);
            alarm_q     <= (state_d == ST_ALARM);
            fail_q      <= fail_d;
            prog_ok_q   <= prog_ok_d;
            prog_err_q  <= prog_err_d;
        end
    end

    assign bus.unlocked      = unlocked_q;
    assign bus.alarm         = alarm_q;
    assign bus.attempt_count = attempt_q;
    assign bus.fail          = fail_q;
    assign bus.prog_ok       = prog_ok_q;
    assign bus.prog_err      = prog_err_q;
    assign bus.digit_count   = ((state_q == ST_UNLOCKED) && bus.mode_set) ? prog_cnt_q : entry_cnt_q;
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed scenarios plus random keys, all checked
// against a digit-queue model of the lock's behaviour.
module tb_keypad_lock_ctrl;
    localparam int          DIGITS = 8;
    localparam int          MAXA   = 3;
    localparam int          UCYC   = 1000;
    localparam logic [31:0] DEF    = 32'h21935488;

    localparam int P_ENTRY = 0, P_CHECK = 1, P_UNL = 2, P_ALARM = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    keypad_lock_ctrl_if #(.DIGITS(DIGITS), .MAX_ATTEMPTS(MAXA)) bus ();

    keypad_lock_ctrl #(
        .DIGITS(DIGITS), .MAX_ATTEMPTS(MAXA), .UNLOCK_CYCLES(UCYC), .DEFAULT_CODE(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: digits kept as queues, first key pressed at index 0.
    int m_entry[$];
    int m_prog[$];
    int m_pass[$];
    int m_phase;
    int m_att;
    int m_left;
    bit m_fail, m_pok, m_perr;

    function automatic void m_reset();
        logic [31:0] d;
        d = DEF;
        m_entry.delete(); m_prog.delete(); m_pass.delete();
        for (int i = 0; i < DIGITS; i++) m_pass.push_back(int'((d >> (4 * (DIGITS - 1 - i))) & 32'hF));
        m_phase = P_ENTRY; m_att = 0; m_left = 0;
        m_fail = 0; m_pok = 0; m_perr = 0;
    endfunction

    function automatic bit same_code();
        if (m_entry.size() != DIGITS) return 1'b0;
        for (int i = 0; i < DIGITS; i++) if (m_entry[i] != m_pass[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step();
        int c;
        c = int'(bus.key_code);
        m_fail = 0; m_pok = 0; m_perr = 0;
        if (rst) begin
            m_reset();
        end else begin
            case (m_phase)
                P_ENTRY: if (bus.key_valid) begin
                    if (c < 10) begin if (m_entry.size() < DIGITS) m_entry.push_back(c); end
                    else if (c == 12) m_entry.delete();
                    else if (c == 14) m_phase = P_CHECK;
                end
                P_CHECK: begin
                    if (same_code()) begin m_phase = P_UNL; m_att = 0; m_left = UCYC; end
                    else begin
                        m_fail = 1; m_att++;
                        m_phase = (m_att == MAXA) ? P_ALARM : P_ENTRY;
                    end
                    m_entry.delete();
                end
                P_UNL: if (bus.mode_set) begin
                    if (bus.key_valid) begin
                        if (c < 10) begin if (m_prog.size() < DIGITS) m_prog.push_back(c); end
                        else if (c == 12) m_prog.delete();
                        else if (c == 14) begin
                            if (m_prog.size() == DIGITS) begin m_pass = m_prog; m_pok = 1; m_phase = P_ENTRY; end
                            else m_perr = 1;
                            m_prog.delete();
                        end
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_ENTRY; m_prog.delete(); end
                end
                default: if (bus.alarm_clr) begin
                    m_phase = P_ENTRY; m_att = 0; m_entry.delete(); m_prog.delete();
                end
            endcase
        end
    endfunction

    function automatic logic [10:0] m_vec();
        logic [3:0] dc;
        dc = (m_phase == P_UNL && bus.mode_set) ? 4'(m_prog.size()) : 4'(m_entry.size());
        return {m_phase == P_UNL, m_phase == P_ALARM, 2'(m_att), dc, m_fail, m_pok, m_perr};
    endfunction

    function automatic logic [10:0] d_vec();
        return {bus.unlocked, bus.alarm, bus.attempt_count, bus.digit_count, bus.fail, bus.prog_ok, bus.prog_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        bus.key_valid = 1'b1; bus.key_code = code;
        tick();
        bus.key_valid = 1'b0; bus.key_code = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.key_valid = 1'b0; bus.key_code = 4'h0; bus.mode_set = 1'b0; bus.alarm_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if (d_vec() !== 11'd0) begin bad++; $display("FAIL reset_outputs: got %b want %b", d_vec(), 11'd0); end
        total++;
        if (d_vec() !== m_vec()) begin bad++; $display("FAIL reset_model: got %b want %b", d_vec(), m_vec()); end
    endtask

    task automatic test_unlock();
        int keys[8] = '{2, 1, 9, 3, 5, 4, 8, 8};
        int hi;
        foreach (keys[i]) begin
            press(4'(keys[i]));
            total++;
            if (d_vec() !== m_vec()) begin bad++; $display("FAIL unlock_key%0d: got %b want %b", i, d_vec(), m_vec()); end
        end
        press(4'hE);
        total++;
        if (bus.unlocked !== 1'b0) begin bad++; $display("FAIL unlock_check_cycle: got %b want 0", bus.unlocked); end
        tick();
        total++;
        if ({bus.unlocked, bus.attempt_count} !== 3'b100) begin
            bad++; $display("FAIL unlock_latency: got %b want 100", {bus.unlocked, bus.attempt_count});
        end
        hi = 1;
        for (int n = 0; n < UCYC + 100; n++) begin
            tick();
            total++;
            if (d_vec() !== m_vec()) begin bad++; $display("FAIL unlock_hold: got %b want %b", d_vec(), m_vec()); end
            if (bus.unlocked) hi++; else break;
        end
        total++;
        if (hi !== UCYC) begin bad++; $display("FAIL unlock_width: got %0d want %0d", hi, UCYC); end
    endtask

    task automatic test_attempts();
        press(4'd2); press(4'd1); press(4'd9); press(4'hE);
        tick();
        total++;
        if ({bus.fail, bus.attempt_count} !== 3'b101) begin bad++; $display("FAIL short_fail: got %b want 101", {bus.fail, bus.attempt_count}); end
        tick();
        total++;
        if (bus.fail !== 1'b0) begin bad++; $display("FAIL fail_pulse_width: got %b want 0", bus.fail); end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DIGITS; i++) press(4'd1);
            press(4'hE);
            tick();
            total++;
            if (d_vec() !== m_vec()) begin bad++; $display("FAIL wrong_code%0d: got %b want %b", r, d_vec(), m_vec()); end
        end
        total++;
        if ({bus.alarm, bus.attempt_count} !== 3'b111) begin bad++; $display("FAIL alarm_set: got %b want 111", {bus.alarm, bus.attempt_count}); end
        press(4'd3); press(4'hE); tick();
        total++;
        if ({bus.alarm, bus.digit_count, bus.fail} !== 6'b100000) begin
            bad++; $display("FAIL alarm_ignores_keys: got %b want 100000", {bus.alarm, bus.digit_count, bus.fail});
        end
        bus.alarm_clr = 1'b1;
        press(4'd5);
        bus.alarm_clr = 1'b0;
        total++;
        if (d_vec() !== 11'd0) begin bad++; $display("FAIL alarm_clr: got %b want %b", d_vec(), 11'd0); end
        press(4'd6);
        bus.alarm_clr = 1'b1; tick(); bus.alarm_clr = 1'b0;
        total++;
        if (d_vec() !== m_vec()) begin bad++; $display("FAIL clr_outside_alarm: got %b want %b", d_vec(), m_vec()); end
        press(4'hC);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 10; i++) press(4'(i % 10));
        total++;
        if (bus.digit_count !== 4'd8) begin bad++; $display("FAIL overflow_count: got %0d want 8", bus.digit_count); end
        press(4'hE);
        press(4'd5);
        total++;
        if ({bus.fail, bus.attempt_count, bus.digit_count} !== 7'b1010000) begin
            bad++; $display("FAIL overflow_fail: got %b want 1010000", {bus.fail, bus.attempt_count, bus.digit_count});
        end
    endtask

    task automatic enter_code(input logic [31:0] code);
        for (int i = DIGITS - 1; i >= 0; i--) press(4'((code >> (4 * i)) & 32'hF));
        press(4'hE);
        tick();
    endtask

    task automatic test_program();
        enter_code(DEF);
        bus.mode_set = 1'b1;
        for (int i = 0; i < DIGITS; i++) press(4'd7);
        total++;
        if (bus.digit_count !== 4'd8) begin bad++; $display("FAIL prog_count: got %0d want 8", bus.digit_count); end
        press(4'hE);
        total++;
        if ({bus.prog_ok, bus.unlocked} !== 2'b10) begin bad++; $display("FAIL prog_ok: got %b want 10", {bus.prog_ok, bus.unlocked}); end
        bus.mode_set = 1'b0;
        enter_code(DEF);
        total++;
        if ({bus.fail, bus.unlocked} !== 2'b10) begin bad++; $display("FAIL old_code: got %b want 10", {bus.fail, bus.unlocked}); end
        enter_code(32'h77777777);
        total++;
        if (bus.unlocked !== 1'b1) begin bad++; $display("FAIL new_code: got %b want 1", bus.unlocked); end
        bus.mode_set = 1'b1;
        press(4'd1); press(4'd2); press(4'd3); press(4'hE);
        total++;
        if ({bus.prog_err, bus.unlocked, bus.digit_count} !== 6'b110000) begin
            bad++; $display("FAIL prog_err: got %b want 110000", {bus.prog_err, bus.unlocked, bus.digit_count});
        end
        press(4'd4); press(4'd5);
        bus.mode_set = 1'b0; tick();
        total++;
        if (d_vec() !== m_vec()) begin bad++; $display("FAIL mode_drop: got %b want %b", d_vec(), m_vec()); end
        bus.mode_set = 1'b1; #1;
        total++;
        if (bus.digit_count !== 4'd2) begin bad++; $display("FAIL mode_keep: got %0d want 2", bus.digit_count); end
        press(4'hC);
        total++;
        if (bus.digit_count !== 4'd0) begin bad++; $display("FAIL prog_clear: got %0d want 0", bus.digit_count); end
        bus.mode_set = 1'b0;
        for (int n = 0; n < UCYC + 10; n++) begin
            tick();
            total++;
            if (d_vec() !== m_vec()) begin bad++; $display("FAIL relock_wait: got %b want %b", d_vec(), m_vec()); end
            if (!bus.unlocked) break;
        end
        total++;
        if (bus.unlocked !== 1'b0) begin bad++; $display("FAIL relock: got %b want 0", bus.unlocked); end
    endtask

    task automatic test_rst_check();
        for (int i = 0; i < DIGITS; i++) press(4'd7);
        press(4'hE);
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (d_vec() !== 11'd0) begin bad++; $display("FAIL rst_in_check: got %b want %b", d_vec(), 11'd0); end
        enter_code(32'h77777777);
        total++;
        if ({bus.fail, bus.unlocked} !== 2'b10) begin bad++; $display("FAIL rst_code_restore: got %b want 10", {bus.fail, bus.unlocked}); end
        enter_code(DEF);
        bus.mode_set = 1'b1; press(4'd9); press(4'd9);
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (d_vec() !== 11'd0) begin bad++; $display("FAIL rst_in_prog: got %b want %b", d_vec(), 11'd0); end
        bus.mode_set = 1'b0;
    endtask

    task automatic test_random();
        int r, sz;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            bus.alarm_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) bus.mode_set = ~bus.mode_set;
            bus.key_valid = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            sz = (m_phase == P_UNL && bus.mode_set) ? m_prog.size() : m_entry.size();
            if (r < 6) bus.key_code = (sz < DIGITS) ? 4'(m_pass[sz]) : 4'hE;
            else if (r < 8) bus.key_code = 4'($urandom_range(0, 15));
            else if (r == 8) bus.key_code = 4'hE;
            else bus.key_code = 4'hC;
            tick();
            total++;
            if (d_vec() !== m_vec()) begin bad++; $display("FAIL random_cycle%0d: got %b want %b", n, d_vec(), m_vec()); end
        end
        rst = 1'b0; bus.key_valid = 1'b0; bus.alarm_clr = 1'b0; bus.mode_set = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_reset();
        test_reset();
        test_unlock();
        test_attempts();
        test_overflow();
        test_program();
        test_rst_check();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
